// File: rtl/pipe_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_issue_ctrl_pkg
// Shared constants and types for the pipe_4_stage issue/collection controller.
//   DATA_W       : sample / result width
//   STAGES       : number of pipe_4_stage stages
//   PIPE_REG_LAT : internal registers inside pipe_4_stage (S1to2, S2to3, S3to4)
//   state_t      : issue FSM encoding
//   cfg_t        : configuration shared by every pipeline stage
//   res_t        : one result FIFO entry
// -----------------------------------------------------------------------------
package pipe_issue_ctrl_pkg;

  localparam int DATA_W       = 32;
  localparam int STAGES       = 4;
  localparam int PIPE_REG_LAT = STAGES - 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  typedef struct packed {
    logic addr;
    logic sel_sum;
  } cfg_t;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              ovf;
  } res_t;

  localparam int RES_W = $bits(res_t);

endpackage

// File: rtl/pipe_res_fifo.sv
// -----------------------------------------------------------------------------
// pipe_res_fifo
// First-word-fall-through FIFO holding pipeline results.
//   clk, rst   : clock, synchronous active-high reset (pointers only)
//   i_wr_en    : write request, i_wr_data written at the edge
//   i_rd_en    : pop request, honoured only while o_valid
//   o_rd_data  : head entry (meaningful only while o_valid)
//   o_valid    : FIFO not empty
// A write and a pop in the same cycle are both performed. A write into a full
// FIFO is dropped unless a pop frees the slot in the same cycle; the issue
// side's credit scheme never lets that happen.
// -----------------------------------------------------------------------------
module pipe_res_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_do_rd;
  logic w_do_wr;

  // Extra MSB on the pointers distinguishes full from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_rd = i_rd_en && !w_empty;
  assign w_do_wr = i_wr_en && (!w_full || w_do_rd);

  assign o_valid   = !w_empty;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_issue_ctrl
// Issue and collection controller wrapped around pipe_4_stage.
//
//   state | meaning
//   ------+-------------------------------------------------------------------
//   RUN   | accepting requests; a cfg change is taken only with the pipe empty
//   DRAIN | a request with a new cfg is waiting; no accepts until v0..v3 clear
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_ready       : request handshake
//   req_x, req_addr,
//   req_sel_sum               : sample and its configuration
//   pipe_x/num/sum/addr/
//   sel_sum/overflow          : drive to the pipeline inputs
//   pipe_res_sum/res_ovf      : stage-4 result from the pipeline
//   res_valid/res_ready       : result handshake (FWFT FIFO head)
//   res_sum, res_ovf          : FIFO head contents, zero while empty
//   busy                      : any sample in flight or queued
//   ovf_count                 : saturating count of results flagged overflow
// -----------------------------------------------------------------------------
module pipe_issue_ctrl
  import pipe_issue_ctrl_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int OVF_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [DATA_W-1:0]    req_x,
  input  logic                 req_addr,
  input  logic                 req_sel_sum,
  output logic [DATA_W-1:0]    pipe_x,
  output logic [DATA_W-1:0]    pipe_num,
  output logic [DATA_W-1:0]    pipe_sum,
  output logic                 pipe_addr,
  output logic                 pipe_sel_sum,
  output logic                 pipe_overflow,
  input  logic [DATA_W-1:0]    pipe_res_sum,
  input  logic                 pipe_res_ovf,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_W-1:0]    res_sum,
  output logic                 res_ovf,
  output logic                 busy,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);

  state_t              r_state;
  logic [DATA_W-1:0]   r_x;
  cfg_t                r_cfg;
  // r_v[0] = issue register valid, r_v[1..3] follow S1to2/S2to3/S3to4.
  logic [PIPE_REG_LAT:0] r_v;
  logic [CW-1:0]       r_credit;
  logic [OVF_CNT_W-1:0] r_ovf_count;

  cfg_t  w_req_cfg;
  logic  w_pipe_empty;
  logic  w_cfg_match;
  logic  w_credit_ok;
  logic  w_accept;
  logic  w_pop;
  logic  w_wr;
  res_t  w_wr_data;
  res_t  w_head;
  logic  w_fifo_valid;

  assign w_req_cfg    = '{addr: req_addr, sel_sum: req_sel_sum};
  assign w_pipe_empty = (r_v == '0);
  assign w_cfg_match  = (w_req_cfg == r_cfg);
  assign w_credit_ok  = (r_credit < CREDIT_MAX);

  // addr/sel_sum are shared by every stage, so a new cfg may only enter an
  // empty pipe; matching requests stream through at full rate.
  always_comb begin
    req_ready = 1'b0;
    if (r_state == ST_RUN) begin
      req_ready = w_credit_ok && (w_pipe_empty || w_cfg_match);
    end
  end

  assign w_accept = req_valid && req_ready;
  assign w_pop    = w_fifo_valid && res_ready;
  assign w_wr     = r_v[PIPE_REG_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_x         <= '0;
      r_cfg       <= '0;
      r_v         <= '0;
      r_credit    <= '0;
      r_ovf_count <= '0;
    end else begin
      r_v <= {r_v[PIPE_REG_LAT-1:0], w_accept};

      if (w_accept) begin
        r_x   <= req_x;
        r_cfg <= w_req_cfg;
      end

      case (r_state)
        ST_RUN: begin
          if (req_valid && !w_cfg_match && !w_pipe_empty) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pipe_empty) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase

      // Credits cover in-flight plus queued entries, so a stage-4 result
      // always finds a free FIFO slot.
      case ({w_accept, w_pop})
        2'b10:   r_credit <= r_credit + CW'(1);
        2'b01:   r_credit <= r_credit - CW'(1);
        default: r_credit <= r_credit;
      endcase

      if (w_wr && pipe_res_ovf && (r_ovf_count != '1)) begin
        r_ovf_count <= r_ovf_count + OVF_CNT_W'(1);
      end
    end
  end

  assign w_wr_data = '{sum: pipe_res_sum, ovf: pipe_res_ovf};

  pipe_res_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_valid   (w_fifo_valid)
  );

  assign pipe_x        = r_x;
  assign pipe_num      = r_x;
  assign pipe_sum      = '0;
  assign pipe_overflow = 1'b0;
  assign pipe_addr     = r_cfg.addr;
  assign pipe_sel_sum  = r_cfg.sel_sum;

  assign res_valid = w_fifo_valid;
  assign res_sum   = w_fifo_valid ? w_head.sum : '0;
  assign res_ovf   = w_fifo_valid ? w_head.ovf : 1'b0;
  assign busy      = (r_credit != '0);
  assign ovf_count = r_ovf_count;

endmodule
